// File: rtl/alu_instr_encoder.sv
// Encodes ALU control requests into RV32 R/I-type instruction words and queues
// them in a 2-entry FIFO, with illegal-request flagging and activity counters.
module alu_instr_encoder #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_control,
  input  logic             in_is_imm,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [11:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_aluop,
  output logic             out_funct7,
  output logic [2:0]       out_funct3,
  output logic             err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [3:0] {
    C_AND  = 4'b0000,
    C_OR   = 4'b0001,
    C_ADD  = 4'b0010,
    C_SLL  = 4'b0011,
    C_SLT  = 4'b0100,
    C_SLTU = 4'b0101,
    C_SUB  = 4'b0110,
    C_XOR  = 4'b0111,
    C_SRL  = 4'b1000,
    C_SRA  = 4'b1010
  } ctrl_e;

  logic        legal;
  logic        shift;
  logic        f7b;
  logic [2:0]  f3;
  logic [6:0]  funct7;
  logic [31:0] word;

  always_comb begin
    legal = 1'b1;
    shift = 1'b0;
    f7b   = 1'b0;
    f3    = '0;
    case (in_control)
      C_ADD:  f3 = 3'b000;
      C_SUB:  begin f3 = 3'b000; f7b = 1'b1; end
      C_AND:  f3 = 3'b111;
      C_OR:   f3 = 3'b110;
      C_SLL:  begin f3 = 3'b001; shift = 1'b1; end
      C_SLT:  f3 = 3'b010;
      C_SLTU: f3 = 3'b011;
      C_XOR:  f3 = 3'b100;
      C_SRL:  begin f3 = 3'b101; shift = 1'b1; end
      C_SRA:  begin f3 = 3'b101; shift = 1'b1; f7b = 1'b1; end
      default: legal = 1'b0;
    endcase
    if (in_is_imm && (in_control == C_SUB))
      legal = 1'b0;
    funct7 = {1'b0, f7b, 5'b00000};
    if (!in_is_imm)
      word = {funct7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
    else if (shift)
      word = {funct7, in_imm[4:0], in_rs1, f3, in_rd, 7'b0010011};
    else
      word = {in_imm, in_rs1, f3, in_rd, 7'b0010011};
  end

  logic [31:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] head;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  // Only the word is stored; aluop and funct fields are recovered from it,
  // and all head outputs read zero while the FIFO is empty.
  always_comb begin
    out_instr  = '0;
    out_aluop  = '0;
    out_funct7 = 1'b0;
    out_funct3 = '0;
    if (out_valid) begin
      out_instr  = head;
      out_aluop  = head[5] ? 2'b10 : 2'b11;
      out_funct7 = head[30];
      out_funct3 = head[14:12];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++)
        mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      enc_cnt <= '0;
      err_cnt <= '0;
    end else begin
      err <= accept && !legal;
      if (pop)
        enc_cnt <= enc_cnt + CNT_W'(1);
      if (accept && !legal && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Directed plus randomized bench for alu_instr_encoder against a queue-based
// reference model computed with plain arithmetic from the encoding rules.
module tb_alu_instr_encoder;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ERR_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_control;
  logic             in_is_imm;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [11:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [1:0]       out_aluop;
  logic             out_funct7;
  logic [2:0]       out_funct3;
  logic             err;
  logic [CNT_W-1:0] enc_cnt;
  logic [ERR_W-1:0] err_cnt;

  alu_instr_encoder #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_control(in_control), .in_is_imm(in_is_imm),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_aluop(out_aluop), .out_funct7(out_funct7), .out_funct3(out_funct3),
    .err(err), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          legal;
    logic [31:0] instr;
    logic [1:0]  aluop;
    logic        f7;
    logic [2:0]  f3;
  } item_t;

  item_t       exp_q[$];
  logic        err_exp;
  int unsigned enc_exp;
  int unsigned errc_exp;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic item_t model_enc(input longint unsigned ctrl, input bit is_i,
                                      input longint unsigned rd, input longint unsigned rs1,
                                      input longint unsigned rs2, input longint unsigned imm);
    item_t r;
    longint unsigned f3, f7, w;
    bit sh;
    r.legal = 1'b1;
    f7 = 0;
    sh = 1'b0;
    case (ctrl)
      2:  f3 = 0;
      6:  begin f3 = 0; f7 = 32; end
      0:  f3 = 7;
      1:  f3 = 6;
      3:  begin f3 = 1; sh = 1'b1; end
      4:  f3 = 2;
      5:  f3 = 3;
      7:  f3 = 4;
      8:  begin f3 = 5; sh = 1'b1; end
      10: begin f3 = 5; f7 = 32; sh = 1'b1; end
      default: begin f3 = 0; r.legal = 1'b0; end
    endcase
    if (ctrl == 6 && is_i) r.legal = 1'b0;
    if (!is_i)
      w = f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 51;
    else if (sh)
      w = f7 * 33554432 + (imm % 32) * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 19;
    else
      w = imm * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 19;
    r.instr = w[31:0];
    r.aluop = is_i ? 2'd3 : 2'd2;
    r.f7    = r.instr[30];
    r.f3    = f3[2:0];
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    err_exp  = 1'b0;
    enc_exp  = 0;
    errc_exp = 0;
  endtask

  // One clock: check pre-edge outputs, advance model at the edge, check registered outputs.
  task automatic cycle(output bit acc);
    item_t it;
    bit    pop;
    check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check("out_instr", out_instr, exp_q[0].instr);
      check("out_aluop", 32'(out_aluop), 32'(exp_q[0].aluop));
      check("out_funct7", 32'(out_funct7), 32'(exp_q[0].f7));
      check("out_funct3", 32'(out_funct3), 32'(exp_q[0].f3));
    end
    acc = in_valid && (exp_q.size() < 2);
    pop = (exp_q.size() > 0) && out_ready;
    it  = model_enc(in_control, in_is_imm, in_rd, in_rs1, in_rs2, in_imm);
    @(posedge clk);
    if (pop) begin
      void'(exp_q.pop_front());
      enc_exp = (enc_exp + 1) % (1 << CNT_W);
    end
    if (acc && it.legal) exp_q.push_back(it);
    err_exp = acc && !it.legal;
    if (err_exp && errc_exp < (1 << ERR_W) - 1) errc_exp++;
    #1;
    check("err", 32'(err), 32'(err_exp));
    check("enc_cnt", 32'(enc_cnt), enc_exp);
    check("err_cnt", 32'(err_cnt), errc_exp);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] c, input logic i, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    in_valid = 1'b1; in_control = c; in_is_imm = i;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic drive_random(input bit illegal_only);
    logic [3:0] c;
    logic       i;
    i = 1'($urandom_range(0, 1));
    if (illegal_only) begin
      case ($urandom_range(0, 2))
        0: c = 4'd9;
        1: c = 4'($urandom_range(11, 15));
        default: begin c = 4'd6; i = 1'b1; end
      endcase
    end else begin
      c = 4'($urandom_range(0, 15));
    end
    drive(c, i, 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom));
  endtask

  bit acc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_control = '0; in_is_imm = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    model_reset();
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_aluop", 32'(out_aluop), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_enc_cnt", 32'(enc_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x3,x1,x2
    out_ready = 1'b1;
    drive(4'b0010, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
    cycle(acc);
    in_valid = 1'b0;
    check("add_instr", out_instr, 32'h002081B3);
    check("add_aluop", 32'(out_aluop), 32'd2);
    cycle(acc);
    check("add_enc_cnt", 32'(enc_cnt), 32'd1);

    // SRAI x5,x6,7
    drive(4'b1010, 1'b1, 5'd5, 5'd6, 5'd0, 12'h007);
    cycle(acc);
    in_valid = 1'b0;
    check("srai_instr", out_instr, 32'h40735293);
    check("srai_funct7", 32'(out_funct7), 32'd1);
    check("srai_funct3", 32'(out_funct3), 32'd5);
    cycle(acc);

    // ADDI x1,x0,-1
    drive(4'b0010, 1'b1, 5'd1, 5'd0, 5'd0, 12'hFFF);
    cycle(acc);
    in_valid = 1'b0;
    check("addi_instr", out_instr, 32'hFFF00093);
    check("addi_aluop", 32'(out_aluop), 32'd3);
    cycle(acc);

    // Backpressure: three requests with out_ready low
    out_ready = 1'b0;
    drive(4'b0000, 1'b0, 5'd7, 5'd8, 5'd9, 12'd0);
    cycle(acc);
    drive(4'b0111, 1'b1, 5'd10, 5'd11, 5'd0, 12'h5A5);
    cycle(acc);
    check("full_in_ready", 32'(in_ready), 32'd0);
    drive(4'b1000, 1'b1, 5'd12, 5'd13, 5'd0, 12'hFE3);
    for (int k = 0; k < 3; k++) cycle(acc);
    check("held_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && !acc; k++) cycle(acc);
    check("third_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) cycle(acc);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_enc_cnt", 32'(enc_cnt), 32'd6);

    // Illegal requests
    drive(4'b0110, 1'b1, 5'd1, 5'd2, 5'd3, 12'd4);
    cycle(acc);
    check("ill1_err", 32'(err), 32'd1);
    drive(4'b1111, 1'b0, 5'd1, 5'd2, 5'd3, 12'd4);
    cycle(acc);
    in_valid = 1'b0;
    cycle(acc);
    check("ill_err_cnt", 32'(err_cnt), 32'd2);
    check("ill_no_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 300; k++) begin
      drive_random(1'b1);
      cycle(acc);
    end
    in_valid = 1'b0;
    cycle(acc);
    check("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Randomized mixed traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) != 0) drive_random(1'b0);
      else in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 2) != 0);
      cycle(acc);
    end

    // Asynchronous reset with two words buffered
    out_ready = 1'b0;
    drive(4'b0011, 1'b1, 5'd2, 5'd3, 5'd0, 12'h01F);
    cycle(acc);
    cycle(acc);
    for (int k = 0; k < 4 && exp_q.size() < 2; k++) cycle(acc);
    in_valid = 1'b0;
    check("pre_rst_count", 32'(exp_q.size()), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_enc_cnt", 32'(enc_cnt), 32'd0);
    check("arst_err_cnt", 32'(err_cnt), 32'd0);
    check("arst_out_instr", out_instr, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(4'b0001, 1'b0, 5'd4, 5'd5, 5'd6, 12'd0);
    cycle(acc);
    in_valid = 1'b0;
    check("post_rst_head", out_instr, 32'h0062E233);
    cycle(acc);
    cycle(acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
